lut_config_loader: RTL and testbench

- Upstream configuration stage for the LUT-mux fabric (the `fgpa` array of l1_mux..l7_mux cells, each holding a 33-bit config word `mem[32:0]`).
- Accepts a byte-serial bitstream over a valid/ready handshake.
- Assembles one 33-bit frame per LUT cell and issues a one-cycle write strobe with cell index and data.
- Validates an XOR checksum and reports done or error; replaces hierarchical testbench preloading of LUT memories.

---
 rtl/lut_config_loader.sv | 173 +++++++++++++++++
 tb/tb_lut_config_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// Byte-serial configuration loader for the LUT-mux fabric: takes a synced
// bitstream, assembles one 33-bit word per LUT cell, issues a single-cycle
// write strobe per cell and reports checksum pass/fail.
module lut_config_loader #(
  parameter int unsigned NUM_LUTS  = 7,
  parameter int unsigned SEL_W     = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cfg_we,
  output logic [SEL_W-1:0] cfg_sel,
  output logic [32:0]      cfg_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned TT_W        = 32;
  localparam int unsigned DATA_W      = 33;
  localparam int unsigned LAST_IDX    = NUM_LUTS - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_TERM  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SEL_W-1:0]   frame_idx_q, frame_idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [TT_W-1:0]    frame_q, frame_d;
  logic               in_ready_q, in_ready_d;
  logic               cfg_we_q, cfg_we_d;
  logic [SEL_W-1:0]   cfg_sel_q, cfg_sel_d;
  logic [DATA_W-1:0]  cfg_data_q, cfg_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic xfer;
  logic is_sync;
  logic last_byte;
  logic last_frame;

  assign xfer       = in_valid & in_ready_q;
  assign is_sync    = (in_data == SYNC_BYTE);
  assign last_byte  = (byte_cnt_q == CNT_W'(FRAME_BYTES - 1));
  assign last_frame = (frame_idx_q == SEL_W'(LAST_IDX));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer && is_sync) state_d = S_LOAD;
      S_LOAD:  if (xfer && last_byte) state_d = S_WRITE;
      S_WRITE: state_d = last_frame ? S_CHECK : S_LOAD;
      S_CHECK: if (xfer) state_d = S_TERM;
      S_TERM:  if (xfer && is_sync) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    frame_idx_d = frame_idx_q;
    csum_d      = csum_q;
    frame_d     = frame_q;
    cfg_we_d    = 1'b0;
    cfg_sel_d   = cfg_sel_q;
    cfg_data_d  = cfg_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE, S_TERM: begin
        // A sync byte starts a fresh load; anything else is dropped
        if (xfer && is_sync) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          frame_idx_d = '0;
          byte_cnt_d  = '0;
          csum_d      = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          if (last_byte) begin
            // Mode byte: only bit0 is kept, upper bits still feed the checksum
            cfg_data_d = {in_data[0], frame_q};
            cfg_sel_d  = frame_idx_q;
            cfg_we_d   = 1'b1;
            byte_cnt_d = '0;
          end else begin
            frame_d    = {in_data, frame_q[TT_W-1:8]};
            byte_cnt_d = CNT_W'(byte_cnt_q + 1'b1);
          end
        end
      end
      S_WRITE: begin
        frame_idx_d = SEL_W'(frame_idx_q + 1'b1);
      end
      S_CHECK: begin
        if (xfer) begin
          busy_d  = 1'b0;
          done_d  = (in_data == csum_q);
          error_d = (in_data != csum_q);
        end
      end
      default: ;
    endcase
    // Input is only refused during the single write cycle
    in_ready_d = (state_d != S_WRITE);
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      frame_idx_q <= '0;
      csum_q      <= '0;
      frame_q     <= '0;
      in_ready_q  <= 1'b1;
      cfg_we_q    <= 1'b0;
      cfg_sel_q   <= '0;
      cfg_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      frame_idx_q <= frame_idx_d;
      csum_q      <= csum_d;
      frame_q     <= frame_d;
      in_ready_q  <= in_ready_d;
      cfg_we_q    <= cfg_we_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_data_q  <= cfg_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign cfg_we   = cfg_we_q;
  assign cfg_sel  = cfg_sel_q;
  assign cfg_data = cfg_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: table of full-bitstream scenarios
// plus hand sequences for restart-after-error and reset mid-load.
module tb_lut_config_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [32:0] cfg_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [32:0] wr_data[$];
  logic [2:0]  wr_sel[$];
  logic        prev_we = 1'b0;

  lut_config_loader #(.NUM_LUTS(7), .SEL_W(3), .SYNC_BYTE(8'hA5)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          garbage;
    logic [7:0]  b4;
    logic [7:0]  csum;
    bit          throttle;
    logic [32:0] exp_data;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Write capture, plus per-cycle strobe/ready relationship
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (in_ready !== !cfg_we) begin
        errors++;
        $display("FAIL ready_vs_we: in_ready=%b cfg_we=%b", in_ready, cfg_we);
      end
      checks++;
      if (cfg_we && prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: cfg_we high two cycles");
      end
    end
    if (cfg_we === 1'b1) begin
      wr_data.push_back(cfg_data);
      wr_sel.push_back(cfg_sel);
    end
    prev_we = cfg_we;
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wr_data.delete();
    wr_sel.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit throttle);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (throttle) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] b4, input logic [7:0] csum, input bit throttle);
    logic [7:0] fb[4];
    fb = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send(8'hA5, throttle);
    for (int f = 0; f < 7; f++) begin
      for (int k = 0; k < 4; k++) send(fb[k], throttle);
      send(b4, throttle);
    end
    send(csum, throttle);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_cfg_we"},   64'(cfg_we),   64'(0));
    check({tag, "_cfg_sel"},  64'(cfg_sel),  64'(0));
    check({tag, "_cfg_data"}, 64'(cfg_data), 64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_done"},     64'(done),     64'(0));
    check({tag, "_error"},    64'(error),    64'(0));
  endtask

  task automatic check_writes(input string tag, input logic [32:0] exp_data);
    check({tag, "_nwrites"}, 64'(wr_data.size()), 64'(7));
    for (int i = 0; i < wr_data.size() && i < 7; i++) begin
      check({tag, "_sel"},  64'(wr_sel[i]),  64'(i));
      check({tag, "_data"}, 64'(wr_data[i]), 64'(exp_data));
    end
  endtask

  initial begin
    logic [7:0] garb[3];
    garb = '{8'h00, 8'hFF, 8'h5A};

    //            name         garb b4     csum   thr exp_data          done err
    vecs[0] = '{"nominal",    0, 8'h01, 8'hC8, 1'b0, 33'h1_CAFEF00D, 1'b1, 1'b0};
    vecs[1] = '{"bad_csum",   0, 8'h01, 8'h00, 1'b0, 33'h1_CAFEF00D, 1'b0, 1'b1};
    vecs[2] = '{"garbage",    3, 8'h01, 8'hC8, 1'b0, 33'h1_CAFEF00D, 1'b1, 1'b0};
    vecs[3] = '{"throttled",  0, 8'h01, 8'hC8, 1'b1, 33'h1_CAFEF00D, 1'b1, 1'b0};
    vecs[4] = '{"mode_fe",    0, 8'hFE, 8'h37, 1'b0, 33'h0_CAFEF00D, 1'b1, 1'b0};
    vecs[5] = '{"mode_fe_bad",0, 8'hFE, 8'hC8, 1'b0, 33'h0_CAFEF00D, 1'b0, 1'b1};

    do_reset();
    check_reset_vals("reset");

    foreach (vecs[v]) begin
      do_reset();
      for (int g = 0; g < vecs[v].garbage; g++) send(garb[g], 1'b0);
      if (vecs[v].garbage > 0) begin
        check({vecs[v].name, "_pre_sync_writes"}, 64'(wr_data.size()), 64'(0));
        check({vecs[v].name, "_pre_sync_busy"},   64'(busy),           64'(0));
      end
      send_stream(vecs[v].b4, vecs[v].csum, vecs[v].throttle);
      check_writes(vecs[v].name, vecs[v].exp_data);
      check({vecs[v].name, "_done"},     64'(done),     64'(vecs[v].exp_done));
      check({vecs[v].name, "_error"},    64'(error),    64'(vecs[v].exp_err));
      check({vecs[v].name, "_busy"},     64'(busy),     64'(0));
      check({vecs[v].name, "_hold_sel"}, 64'(cfg_sel),  64'(6));
      check({vecs[v].name, "_hold_dat"}, 64'(cfg_data), 64'(vecs[v].exp_data));
    end

    // Error is sticky through junk, then cleared by a new sync
    do_reset();
    send_stream(8'h01, 8'h00, 1'b0);
    check("restart_err_before", 64'(error), 64'(1));
    send(8'h33, 1'b0);
    check("restart_err_junk",   64'(error), 64'(1));
    check("restart_busy_junk",  64'(busy),  64'(0));
    send(8'hA5, 1'b0);
    check("restart_err_clr",    64'(error), 64'(0));
    check("restart_done_clr",   64'(done),  64'(0));
    check("restart_busy",       64'(busy),  64'(1));

    // Reset after two frames plus three bytes
    do_reset();
    send(8'hA5, 1'b0);
    for (int f = 0; f < 2; f++) begin
      send(8'h0D, 1'b0); send(8'hF0, 1'b0); send(8'hFE, 1'b0);
      send(8'hCA, 1'b0); send(8'h01, 1'b0);
    end
    send(8'h0D, 1'b0); send(8'hF0, 1'b0); send(8'hFE, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_vals("midrst");
    check("midrst_writes", 64'(wr_data.size()), 64'(2));
    repeat (8) @(posedge clock);
    #1;
    check("midrst_no_3rd", 64'(wr_data.size()), 64'(2));
    wr_data.delete();
    wr_sel.delete();
    send_stream(8'h01, 8'hC8, 1'b0);
    check_writes("midrst_reload", 33'h1_CAFEF00D);
    check("midrst_done",  64'(done),  64'(1));
    check("midrst_error", 64'(error), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
